// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Two-port round-robin front end for one shared sequential
//               signed multiplier. Grants one requester at a time, launches
//               the multiplier, waits for completion (with timeout abort)
//               and holds the response until the consumer accepts it.
// Ports       : clk, rst (async, active-low)
//               req0/a0/b0, req1/a1/b1 -> gnt0/gnt1 (1-cycle accept pulses)
//               mul_start/mul_a/mul_b  -> multiplier; mul_done/mul_product <-
//               rsp_valid/rsp_id/rsp_product/rsp_err -> consumer; rsp_ready <-
//               busy : high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               rsp_err,
  input  logic               rsp_ready,
  output logic               busy
);

  localparam int               CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;

  logic w_any_req;
  logic w_pick;
  logic w_done_ok;
  logic w_timeout;

  // Lone requester wins outright; on a tie the one not served last wins.
  assign w_any_req = req0 | req1;
  assign w_pick    = (req0 & req1) ? ~r_last_grant : req1;

  // The counter is zero only in the first WAIT cycle, so a done level left
  // over from the previous operation cannot complete the new one.
  assign w_done_ok = mul_done & (r_cnt != '0);
  assign w_timeout = (r_cnt == C_TIMEOUT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    mul_start   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any_req) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        mul_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ok || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: grant pulses, operand/id capture, wait counter, response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      r_last_grant <= 1'b1;
      rsp_id       <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      r_cnt        <= '0;
      rsp_product  <= '0;
      rsp_err      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            gnt0         <= ~w_pick;
            gnt1         <= w_pick;
            r_last_grant <= w_pick;
            rsp_id       <= w_pick;
            mul_a        <= w_pick ? a1 : a0;
            mul_b        <= w_pick ? b1 : b0;
          end
        end
        S_START: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          // Completion is checked first so it wins over a same-cycle timeout.
          if (w_done_ok) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
          end else if (w_timeout) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
          end
          if (r_cnt != C_TIMEOUT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter with a behavioural
//               multiplier and a round-robin / latency reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

  localparam int WIDTH   = 6;
  localparam int TIMEOUT = 31;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [WIDTH-1:0]  a0, b0, a1, b1;
  logic              gnt0, gnt1, mul_start;
  logic [WIDTH-1:0]  mul_a, mul_b;
  logic              mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic              rsp_valid, rsp_id;
  logic [2*WIDTH-1:0] rsp_product;
  logic              rsp_err, rsp_ready, busy;

  mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int both_cnt = 0;
  int start_cnt = 0;
  int g1_cnt   = 0;
  int mul_lat  = 12;
  bit stale_mode = 1'b0;
  int m_last   = 1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (gnt0 && gnt1) both_cnt <= both_cnt + 1;
    if (mul_start)    start_cnt <= start_cnt + 1;
    if (gnt1)         g1_cnt <= g1_cnt + 1;
  end

  function automatic logic [11:0] mul12(input logic [5:0] a, input logic [5:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return 12'(x * y);
  endfunction

  // Behavioural multiplier: done rises mul_lat cycles after the cycle
  // following mul_start. In stale mode the old done level lingers into the
  // first cycle after mul_start.
  initial begin : mult_model
    int k;
    bit active;
    logic [11:0] p;
    mul_done = 1'b0; mul_product = '0; k = 0; active = 1'b0; p = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mul_done = 1'b0;
        active   = 1'b0;
      end else if (mul_start) begin
        active = 1'b1;
        k      = 0;
        p      = mul12(mul_a, mul_b);
        if (!stale_mode) mul_done = 1'b0;
      end else if (active) begin
        k++;
        if (k == 2 && stale_mode) mul_done = 1'b0;
        if (k == 1 + mul_lat) begin
          mul_done    = 1'b1;
          mul_product = p;
          active      = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached, summary checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // One transaction: wait for a grant, drop that requester, wait for the
  // response, hold rsp_ready low for 'stall' more cycles, then accept.
  task automatic do_op(input int stall, output int gid, output int lat,
                       output logic [11:0] prod, output logic err, output logic rid,
                       output bit stable, output bit valid_after, output bit tmo);
    int gcyc, n;
    tmo = 0; stable = 1; gid = -1; lat = -1; prod = '0; err = 0; rid = 0; valid_after = 0;
    n = 0;
    while (!(gnt0 || gnt1) && n < 60) begin @(negedge clk); n++; end
    if (!(gnt0 || gnt1)) begin tmo = 1; return; end
    gid  = gnt1 ? 1 : 0;
    gcyc = cyc;
    if (gid == 0) req0 = 1'b0; else req1 = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid) begin tmo = 1; return; end
    lat = cyc - gcyc; prod = rsp_product; err = rsp_err; rid = rsp_id;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_product !== prod || rsp_err !== err || rsp_id !== rid) stable = 0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    valid_after = rsp_valid;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_last = 1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({gnt0, gnt1, mul_start, rsp_valid, rsp_id, rsp_err, busy} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000000", {gnt0, gnt1, mul_start, rsp_valid, rsp_id, rsp_err, busy}); end
    checks++; if ({mul_a, mul_b, rsp_product} !== '0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {mul_a, mul_b, rsp_product}); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({busy, gnt0, gnt1} !== 3'b000) begin
        failures++; $display("FAIL idle_stay: got %b expected 000", {busy, gnt0, gnt1}); end
    end
  endtask

  task automatic test_single();
    int gid, lat, s0; logic [11:0] prod; logic err, rid; bit st, va, tmo;
    stale_mode = 0; mul_lat = 12;
    a0 = 6'd3; b0 = 6'b111110; req0 = 1'b1;
    s0 = start_cnt;
    do_op(0, gid, lat, prod, err, rid, st, va, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL single_tmo: got timeout expected response"); end
    checks++; if (gid !== 0) begin failures++; $display("FAIL single_gnt: got %0d expected 0", gid); end
    checks++; if (prod !== 12'hFFA) begin failures++; $display("FAIL single_prod: got %h expected ffa", prod); end
    checks++; if (rid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL single_id_err: got %b%b expected 00", rid, err); end
    checks++; if (lat !== 14) begin failures++; $display("FAIL single_lat: got %0d expected 14", lat); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_start: got %0d expected 1", start_cnt - s0); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL single_drop: got %b expected 0", va); end
  endtask

  task automatic test_tie();
    int gid, lat, exp_id, b0c; logic [11:0] prod, ep; logic err, rid; bit st, va, tmo;
    @(negedge clk);
    rst = 1'b0; repeat (2) @(negedge clk);
    stale_mode = 0; mul_lat = $urandom_range(1, 10);
    a0 = 6'($urandom); b0 = 6'($urandom); a1 = 6'($urandom); b1 = 6'($urandom);
    req0 = 1'b1; req1 = 1'b1; b0c = both_cnt; m_last = 1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (m_last == 1) ? 0 : 1;
      ep = exp_id ? mul12(a1, b1) : mul12(a0, b0);
      do_op(0, gid, lat, prod, err, rid, st, va, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL tie_tmo: op %0d got timeout expected response", i); end
      checks++; if (gid !== exp_id || gid !== (i % 2)) begin failures++; $display("FAIL tie_order: op %0d got %0d expected %0d", i, gid, i % 2); end
      checks++; if (prod !== ep || rid !== exp_id[0]) begin failures++; $display("FAIL tie_rsp: op %0d got %h/%b expected %h/%b", i, prod, rid, ep, exp_id[0]); end
      checks++; if (lat !== mul_lat + 2) begin failures++; $display("FAIL tie_lat: op %0d got %0d expected %0d", i, lat, mul_lat + 2); end
      m_last = exp_id;
      if (exp_id == 0) begin a0 = 6'($urandom); b0 = 6'($urandom); req0 = 1'b1; end
      else begin a1 = 6'($urandom); b1 = 6'($urandom); req1 = 1'b1; end
      mul_lat = $urandom_range(1, 10);
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (both_cnt !== b0c) begin failures++; $display("FAIL tie_overlap: got %0d expected %0d", both_cnt, b0c); end
  endtask

  task automatic test_stale();
    int gid, lat; logic [11:0] prod; logic err, rid; bit st, va, tmo;
    stale_mode = 1; mul_lat = 2;
    a0 = 6'd5; b0 = 6'd7; req0 = 1'b1;
    do_op(0, gid, lat, prod, err, rid, st, va, tmo);
    checks++; if (tmo || prod !== 12'd35) begin failures++; $display("FAIL stale_first: got %h expected 023", prod); end
    mul_lat = 6;
    a1 = 6'b111101; b1 = 6'd4; req1 = 1'b1;
    do_op(0, gid, lat, prod, err, rid, st, va, tmo);
    checks++; if (tmo || prod !== 12'hFF4) begin failures++; $display("FAIL stale_prod: got %h expected ff4", prod); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL stale_lat: got %0d expected 8", lat); end
    checks++; if (err !== 1'b0 || rid !== 1'b1) begin failures++; $display("FAIL stale_err_id: got %b%b expected 01", err, rid); end
  endtask

  task automatic test_timeout();
    int gid, lat, lats[3]; logic [11:0] prod, ep; logic err, rid, eerr; bit st, va, tmo;
    lats[0] = TIMEOUT; lats[1] = TIMEOUT + 1; lats[2] = 500;
    stale_mode = 1;
    for (int i = 0; i < 3; i++) begin
      mul_lat = lats[i];
      a0 = 6'($urandom_range(1, 31)); b0 = 6'($urandom_range(1, 31)); req0 = 1'b1;
      eerr = (lats[i] > TIMEOUT);
      ep   = eerr ? 12'h000 : mul12(a0, b0);
      do_op(0, gid, lat, prod, err, rid, st, va, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL tmo_resp: case %0d got no response expected one", i); end
      checks++; if (err !== eerr) begin failures++; $display("FAIL tmo_err: case %0d got %b expected %b", i, err, eerr); end
      checks++; if (prod !== ep) begin failures++; $display("FAIL tmo_prod: case %0d got %h expected %h", i, prod, ep); end
      checks++; if (lat !== TIMEOUT + 2) begin failures++; $display("FAIL tmo_lat: case %0d got %0d expected %0d", i, lat, TIMEOUT + 2); end
    end
  endtask

  task automatic test_backpressure();
    int gid, lat, g1b; logic [11:0] prod, ep, ep1; logic err, rid; bit st, va, tmo;
    stale_mode = 0; mul_lat = 4;
    a0 = 6'($urandom); b0 = 6'($urandom); req0 = 1'b1;
    ep = mul12(a0, b0);
    g1b = g1_cnt;
    fork
      do_op(4, gid, lat, prod, err, rid, st, va, tmo);
      begin
        repeat (3) @(negedge clk);
        a1 = 6'($urandom); b1 = 6'($urandom); req1 = 1'b1;
      end
    join
    ep1 = mul12(a1, b1);
    checks++; if (tmo || gid !== 0 || prod !== ep) begin failures++; $display("FAIL bp_first: got gnt %0d prod %h expected gnt 0 prod %h", gid, prod, ep); end
    checks++; if (!st) begin failures++; $display("FAIL bp_stable: got changing fields expected constant"); end
    checks++; if (va !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_idle: got valid %b busy %b expected 0 0", va, busy); end
    checks++; if (gnt1 !== 1'b0 || g1_cnt !== g1b) begin failures++; $display("FAIL bp_early_gnt: got gnt1 %b count %0d expected 0 %0d", gnt1, g1_cnt, g1b); end
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL bp_gnt1: got %b expected 1", gnt1); end
    do_op(0, gid, lat, prod, err, rid, st, va, tmo);
    checks++; if (tmo || gid !== 1 || prod !== ep1 || rid !== 1'b1) begin failures++; $display("FAIL bp_second: got gnt %0d prod %h expected gnt 1 prod %h", gid, prod, ep1); end
  endtask

  task automatic test_reset_mid_wait();
    int gid, lat, n; logic [11:0] prod, ep; logic err, rid; bit st, va, tmo;
    stale_mode = 0; mul_lat = 500;
    a0 = 6'($urandom_range(1, 31)); b0 = 6'($urandom_range(1, 31)); req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (!gnt0) begin failures++; $display("FAIL rmw_gnt0: got 0 expected 1"); end
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if ({gnt0, gnt1, mul_start, rsp_valid, rsp_id, rsp_err, busy} !== 7'b0) begin
      failures++; $display("FAIL rmw_ctrl: got %b expected 0000000", {gnt0, gnt1, mul_start, rsp_valid, rsp_id, rsp_err, busy}); end
    checks++; if ({mul_a, mul_b, rsp_product} !== '0) begin
      failures++; $display("FAIL rmw_data: got %h expected 0", {mul_a, mul_b, rsp_product}); end
    @(negedge clk);
    rst = 1'b1; m_last = 1; mul_lat = 3;
    a1 = 6'($urandom); b1 = 6'($urandom); req1 = 1'b1;
    ep = mul12(a1, b1);
    @(posedge clk); #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin failures++; $display("FAIL rmw_first_gnt: got %b%b expected 10", gnt1, gnt0); end
    do_op(0, gid, lat, prod, err, rid, st, va, tmo);
    checks++; if (tmo || gid !== 1 || prod !== ep || err !== 1'b0) begin failures++; $display("FAIL rmw_op: got gnt %0d prod %h err %b expected 1 %h 0", gid, prod, err, ep); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL rmw_lat: got %0d expected 5", lat); end
    m_last = 1;
  endtask

  task automatic test_random();
    int gid, lat, exp_id, elat, L, stall; logic [11:0] prod, ep; logic err, rid, eerr; bit st, va, tmo, p0, p1;
    apply_reset();
    p0 = 0; p1 = 0;
    for (int it = 0; it < 40; it++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin a0 = 6'($urandom); b0 = 6'($urandom); p0 = 1; req0 = 1'b1; end
      if (!p1 && $urandom_range(0, 1) == 1) begin a1 = 6'($urandom); b1 = 6'($urandom); p1 = 1; req1 = 1'b1; end
      if (!p0 && !p1) begin a0 = 6'($urandom); b0 = 6'($urandom); p0 = 1; req0 = 1'b1; end
      exp_id = (p0 && p1) ? ((m_last == 1) ? 0 : 1) : (p1 ? 1 : 0);
      L = $urandom_range(1, 40);
      mul_lat = L; stale_mode = 1'($urandom_range(0, 1));
      eerr = (L > TIMEOUT);
      ep   = eerr ? 12'h000 : (exp_id ? mul12(a1, b1) : mul12(a0, b0));
      elat = (eerr ? TIMEOUT : L) + 2;
      stall = $urandom_range(0, 3);
      do_op(stall, gid, lat, prod, err, rid, st, va, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL rnd_tmo: it %0d got no response expected one", it); end
      checks++; if (gid !== exp_id || rid !== exp_id[0]) begin failures++; $display("FAIL rnd_id: it %0d got %0d/%b expected %0d", it, gid, rid, exp_id); end
      checks++; if (prod !== ep || err !== eerr) begin failures++; $display("FAIL rnd_rsp: it %0d got %h/%b expected %h/%b", it, prod, err, ep, eerr); end
      checks++; if (lat !== elat) begin failures++; $display("FAIL rnd_lat: it %0d got %0d expected %0d", it, lat, elat); end
      checks++; if (!st || va !== 1'b0) begin failures++; $display("FAIL rnd_hold: it %0d got stable %b valid_after %b expected 1 0", it, st, va); end
      m_last = exp_id;
      if (exp_id == 0) p0 = 0; else p1 = 0;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_stale();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
